// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit saturating counters and a registered mispredict redirect
module branch_predictor #(
  parameter int ENTRIES = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] fetch_pc_i,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  input  logic        ex_valid_i,
  input  logic        ex_is_branch_i,
  input  logic [31:0] ex_pc_i,
  input  logic        ex_taken_i,
  input  logic [31:0] ex_target_i,
  input  logic        ex_pred_taken_i,
  input  logic [31:0] ex_pred_target_i,
  output logic        mispredict_o,
  output logic [31:0] redirect_pc_o,
  output logic [15:0] mispredict_cnt_o
);
  localparam int IDX = $clog2(ENTRIES);
  localparam int TW = 30 - IDX;
  logic [ENTRIES-1:0] r_valid;
  logic [TW-1:0]      r_tag [ENTRIES];
  logic [31:0]        r_target [ENTRIES];
  logic [1:0]         r_ctr [ENTRIES];
  logic               r_mis;
  logic [31:0]        r_redirect;
  logic [15:0]        r_cnt;
  logic [IDX-1:0]     w_fidx, w_eidx;
  logic [TW-1:0]      w_ftag, w_etag;
  logic               w_fhit, w_ehit, w_br, w_nb, w_mis;
  logic [31:0]        w_pc4, w_actual;
  logic [1:0]         w_ctr, w_ctr_nxt;
  assign w_fidx = fetch_pc_i[IDX+1:2];
  assign w_ftag = fetch_pc_i[31:IDX+2];
  assign w_fhit = r_valid[w_fidx] && (r_tag[w_fidx] == w_ftag);
  assign pred_taken_o = w_fhit && r_ctr[w_fidx][1];
  assign pred_target_o = pred_taken_o ? r_target[w_fidx] : fetch_pc_i + 32'd4;
  assign w_eidx = ex_pc_i[IDX+1:2];
  assign w_etag = ex_pc_i[31:IDX+2];
  assign w_ehit = r_valid[w_eidx] && (r_tag[w_eidx] == w_etag);
  assign w_br = ex_valid_i && ex_is_branch_i;
  assign w_nb = ex_valid_i && !ex_is_branch_i && ex_pred_taken_i;
  assign w_pc4 = ex_pc_i + 32'd4;
  assign w_actual = ex_taken_i ? ex_target_i : w_pc4;
  // target-only mismatches count too, so compare full next PC rather than direction
  assign w_mis = (w_br && (w_actual != ex_pred_target_i)) || w_nb;
  assign w_ctr = r_ctr[w_eidx];
  assign w_ctr_nxt = ex_taken_i ? ((w_ctr == 2'b11) ? w_ctr : w_ctr + 2'd1)
                                : ((w_ctr == 2'b00) ? w_ctr : w_ctr - 2'd1);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= 2'b01;
      r_mis <= 1'b0;
      r_redirect <= '0;
      r_cnt <= '0;
    end else begin
      if (w_br && w_ehit) r_ctr[w_eidx] <= w_ctr_nxt;
      else if (w_br && ex_taken_i) begin
        r_valid[w_eidx] <= 1'b1;
        r_ctr[w_eidx] <= 2'b10;
      end else if (w_nb && w_ehit) r_valid[w_eidx] <= 1'b0;
      r_mis <= w_mis;
      if (w_mis) r_redirect <= w_br ? w_actual : w_pc4;
      if (w_mis && (r_cnt != 16'hFFFF)) r_cnt <= r_cnt + 16'd1;
    end
  end
  // tags and targets need no reset; valid bits gate them
  always_ff @(posedge clk_i) begin
    if (w_br && ex_taken_i) begin
      r_tag[w_eidx] <= w_etag;
      r_target[w_eidx] <= ex_target_i;
    end
  end
  assign mispredict_o = r_mis;
  assign redirect_pc_o = r_redirect;
  assign mispredict_cnt_o = r_cnt;
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor with a direct-mapped branch target buffer (BTB) and 2-bit saturating counters. On the fetch side it predicts taken/not-taken and a target for the current fetch PC. On the execute side it takes the resolved outcome from the branch comparator (the PC-select bit), trains its tables and raises a registered mispredict/redirect pulse for the PC unit and the pipeline flush logic.

## Interface
- ENTRIES, 16: number of BTB entries; power of 2, ≥2. IDX = log2(ENTRIES).
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- fetch_pc_i  in  32  PC being fetched; bits [1:0] ignored.
- pred_taken_o  out  1  combinational prediction for fetch_pc_i.
- pred_target_o  out  32  predicted next PC: BTB target if pred_taken_o, else fetch_pc_i+4.
- ex_valid_i  in  1  resolving instruction present in execute this cycle.
- ex_is_branch_i  in  1  instruction is a conditional branch.
- ex_pc_i  in  32  PC of resolving instruction.
- ex_taken_i  in  1  resolved outcome (comparator PC-select).
- ex_target_i  in  32  computed branch target.
- ex_pred_taken_i  in  1  prediction carried down the pipe with the instruction.
- ex_pred_target_i  in  32  predicted next PC carried down the pipe.
- mispredict_o  out  1  registered one-cycle redirect pulse.
- redirect_pc_o  out  32  correct next PC; valid when mispredict_o=1.
- mispredict_cnt_o  out  16  saturating count of mispredicts.

## Operation
- Address split: index = pc[IDX+1:2], tag = pc[31:IDX+2].
- Entry fields: valid, tag, target[31:0], ctr[1:0].
- Lookup (combinational): hit = valid & tag match at index. pred_taken_o = hit & ctr[1]. Miss gives not-taken.
- Resolution, when ex_valid_i=1 & ex_is_branch_i=1:
  - actual_next = ex_taken_i ? ex_target_i : ex_pc_i+4.
  - Mispredict when actual_next ≠ ex_pred_target_i. This also covers the case where the direction is correct but the target differs.
  - Hit: ctr saturating increment if taken (max 2'b11), decrement if not taken (min 2'b00). If taken, target ← ex_target_i.
  - Miss and taken: allocate the entry and overwrite any occupant. valid=1, tag, target, ctr=2'b10.
  - Miss and not taken: no table change.
- Non-branch, when ex_valid_i=1 & ex_is_branch_i=0:
  - If ex_pred_taken_i=1, this is a mispredict with redirect to ex_pc_i+4. The matching entry is invalidated if the tag hits.
  - Otherwise no action.
- ex_valid_i=0: no table change and no mispredict.
- mispredict_cnt_o increments by 1 on each mispredict and holds at 16'hFFFF.
- PC arithmetic (+4) is 32-bit modulo: 32'hFFFF_FFFC + 4 = 0.

## Timing
- Reset, asynchronous and taking effect immediately mid-operation:
  - All valid bits = 0 and all ctr = 2'b01; tags and targets are don't-care.
  - mispredict_o=0, redirect_pc_o=0, mispredict_cnt_o=0.
  - Consequently pred_taken_o=0 and pred_target_o=fetch_pc_i+4 right after reset.
- Lookup latency 0: outputs follow fetch_pc_i within the same cycle.
- Update latency 1: a table write on edge N is visible to lookup after edge N.
- Same-cycle lookup and update of the same index: lookup returns pre-update contents.
- mispredict_o and redirect_pc_o are registered. They are asserted for exactly the one cycle after the resolving cycle, then return to 0. redirect_pc_o holds its last value when mispredict_o=0.
- Back-to-back resolutions produce back-to-back pulses, one per instruction. No handshake; the consumer must accept every pulse.

## Test plan
- Reset: deassert rst_ni with fetch_pc_i=32'h100 -> pred_taken_o=0, pred_target_o=32'h104, all outputs 0. Pulse rst_ni low mid-sequence -> mispredict_o drops at once and all tables clear.
- Cold taken branch: resolve pc=32'h40, taken, target 32'h80, pred_target=32'h44 -> next cycle mispredict_o=1, redirect_pc_o=32'h80, cnt=1. Then fetch 32'h40 -> pred_taken_o=1, pred_target_o=32'h80.
- Counter saturation: train pc=32'h40 taken ×3 -> ctr=11. Then not-taken ×1 -> still predicts taken. Second not-taken -> ctr=01, predicts not-taken.
- Aliasing: allocate 32'h40, then resolve 32'h440 taken to 32'h900 (same index, different tag) -> entry replaced; fetch 32'h40 predicts not-taken.
- Non-branch false hit: ex_is_branch_i=0, ex_pred_taken_i=1, pc=32'h40 -> mispredict_o=1, redirect_pc_o=32'h44, entry invalidated.
- Counter saturation at max: preload 16'hFFFE and force 3 mispredicts -> mispredict_cnt_o=16'hFFFF and holds. Target-only mismatch (direction correct, target 32'h80 vs 32'h84) -> mispredict counted.
